cpu_fetch_pc: RTL and testbench
===============================

// Module: cpu_fetch_pc
// PURPOSE
//  Fetch-stage datapath driven by cpu_fetch control: owns PC register, issues instruction-memory reads,
//  tracks the one in-flight read, and loads the fetch/decode pipeline register (decode PC, IR, valid).
//  Computes the next PC: sequential, register-target or PC-relative, with writeback-to-PC forwarding.
//  Applies flush_f so taken branches squash wrong-path instructions.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  NOP_INSTR  16'h0000  IR value inserted on reset, flush or bubble
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   asynchronous active-high reset
//  pc_ld         in   1   load PC this cycle
//  pc_addr_sel   in   2   0:pc+2  1:rX target  2:PC-relative  3:reserved (hold)
//  pc_rd         in   1   issue instruction-memory read at current PC
//  flush_f       in   1   squash in-flight fetch and F/D register
//  decode_pc_ld  in   1   load decode_pc
//  decode_ir_ld  in   1   load decode_ir/decode_valid (0 = decode stall)
//  fwd_pc        in   1   rX target comes from wb_data, not rx_data
//  x_pc          in   16  PC+2 of instruction in execute
//  x_instr       in   16  instruction in execute; imm11 = x_instr[15:5]
//  rx_data       in   16  rX register value for execute instruction
//  wb_data       in   16  result being written back
//  imem_addr     out  16  instruction-memory address (= pc)
//  imem_rd       out  1   instruction-memory read strobe (= pc_rd)
//  imem_rddata   in   16  read data, valid exactly 1 cycle after imem_rd
//  pc            out  16  current fetch PC
//  decode_pc     out  16  PC+2 of instruction in decode
//  decode_ir     out  16  instruction in decode
//  decode_valid  out  1   decode_ir is a real (non-squashed) instruction
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, decode_pc=0, decode_ir=NOP_INSTR, decode_valid=0,
//   f_valid=0, f_pc=0. Reset mid-read: returning imem_rddata is dropped.
//  In-flight tracker: each edge f_valid<=pc_rd & ~flush_f; f_pc<=pc.
//  Next PC (16-bit, wrap modulo 2^16, no overflow flag), applied only when pc_ld=1:
//   sel0: pc+2;  sel1: fwd_pc ? wb_data : rx_data;
//   sel2: x_pc + (sext(imm11)<<1);  sel3: pc unchanged.
//   pc_ld=0: pc holds.
//  F/D register, same edge, priority flush_f > decode_ir_ld:
//   flush_f=1: decode_ir<=NOP_INSTR, decode_valid<=0; decode_pc unchanged.
//   else decode_ir_ld=1: decode_ir<=f_valid ? imem_rddata : NOP_INSTR; decode_valid<=f_valid.
//   else: decode_ir, decode_valid hold (stall); imem_rddata of that cycle is lost, so control
//    must deassert pc_rd/pc_ld while stalling.
//  decode_pc<=f_pc+2 when decode_pc_ld=1 and flush_f=0; else hold.
//  Latency: PC P presented at cycle t -> instruction in decode_ir after edge t+1 (2 cycles).
//  Taken branch: flush_f and pc_ld same cycle; the fetch at old pc (in flight) and the F/D contents
//   are both squashed; target fetched next cycle. Branch penalty: exactly 2 bubbles.
//  imem_addr=pc, imem_rd=pc_rd, combinational; no other combinational in->out paths.
// TESTING
//  1 Reset with RESET_PC=16'h0010, then pc_ld=1 sel0 for 4 cycles -> imem_addr 0010,0012,0014,0016;
//    decode_ir shows mem[0010] on cycle 2, decode_pc=0012, decode_valid=1.
//  2 Taken sel2 branch, x_pc=0020, imm11=11'h7FE (-2) -> pc=001C next cycle; decode_valid=0 for 2 cycles.
//  3 sel1 with fwd_pc=1, wb_data=ABCE, rx_data=1234 -> pc=ABCE; repeat fwd_pc=0 -> pc=1234.
//  4 decode_ir_ld=0, pc_ld=0, pc_rd=0 for 3 cycles -> pc, decode_ir, decode_pc, decode_valid all stable.
//  5 pc=FFFE, sel0 -> pc=0000 (wrap); sel3 with pc_ld=1 -> pc unchanged.
//  6 Assert reset mid-stream with f_valid=1 -> outputs take reset values immediately; first decode
//    after release is decode_valid=0 bubble, then mem[RESET_PC].

Source files
------------

// File: rtl/cpu_fetch_pc.sv
// cpu_fetch_pc: fetch-stage PC, in-flight imem read tracker and F/D pipeline register.
module cpu_fetch_pc #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_ld,
    input  logic [1:0]  pc_addr_sel,
    input  logic        pc_rd,
    input  logic        flush_f,
    input  logic        decode_pc_ld,
    input  logic        decode_ir_ld,
    input  logic        fwd_pc,
    input  logic [15:0] x_pc,
    input  logic [15:0] x_instr,
    input  logic [15:0] rx_data,
    input  logic [15:0] wb_data,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_rddata,
    output logic [15:0] pc,
    output logic [15:0] decode_pc,
    output logic [15:0] decode_ir,
    output logic        decode_valid
);
    logic [15:0] pc_q, pc_d, dpc_q, dpc_d, dir_q, dir_d, f_pc_q, rel_tgt, pc_nxt;
    logic        dv_q, dv_d, f_valid_q;

    // imm11 is a halfword offset relative to the execute instruction's PC+2
    assign rel_tgt = x_pc + {{4{x_instr[15]}}, x_instr[15:5], 1'b0};

    always_comb begin
        pc_nxt = pc_addr_sel == 2'd0 ? pc_q + 16'd2 :
                 pc_addr_sel == 2'd1 ? (fwd_pc ? wb_data : rx_data) :
                 pc_addr_sel == 2'd2 ? rel_tgt : pc_q;
        pc_d   = pc_ld ? pc_nxt : pc_q;
        dir_d  = flush_f ? NOP_INSTR : decode_ir_ld ? (f_valid_q ? imem_rddata : NOP_INSTR) : dir_q;
        dv_d   = flush_f ? 1'b0 : decode_ir_ld ? f_valid_q : dv_q;
        dpc_d  = (decode_pc_ld && !flush_f) ? f_pc_q + 16'd2 : dpc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            dpc_q     <= 16'h0000;
            dir_q     <= NOP_INSTR;
            dv_q      <= 1'b0;
            f_valid_q <= 1'b0;
            f_pc_q    <= 16'h0000;
        end else begin
            pc_q      <= pc_d;
            dpc_q     <= dpc_d;
            dir_q     <= dir_d;
            dv_q      <= dv_d;
            f_valid_q <= pc_rd & ~flush_f;
            f_pc_q    <= pc_q;
        end
    end

    assign imem_addr    = pc_q;
    assign imem_rd      = pc_rd;
    assign pc           = pc_q;
    assign decode_pc    = dpc_q;
    assign decode_ir    = dir_q;
    assign decode_valid = dv_q;
endmodule

// File: tb/tb_cpu_fetch_pc.sv
// tb_cpu_fetch_pc: directed vector table, reset corner sequence and randomized run vs a reference model.
module tb_cpu_fetch_pc;
    localparam logic [15:0] RPC = 16'h0010;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0, reset = 1'b0;
    logic        pc_ld = 0, pc_rd = 0, flush_f = 0, decode_pc_ld = 0, decode_ir_ld = 0, fwd_pc = 0;
    logic [1:0]  pc_addr_sel = 0;
    logic [15:0] x_pc = 0, x_instr = 0, rx_data = 0, wb_data = 0;
    logic [15:0] imem_addr, imem_rddata, pc, decode_pc, decode_ir;
    logic        imem_rd, decode_valid;
    int          checks = 0, fails = 0;

    cpu_fetch_pc #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc_ld(pc_ld), .pc_addr_sel(pc_addr_sel), .pc_rd(pc_rd),
        .flush_f(flush_f), .decode_pc_ld(decode_pc_ld), .decode_ir_ld(decode_ir_ld), .fwd_pc(fwd_pc),
        .x_pc(x_pc), .x_instr(x_instr), .rx_data(rx_data), .wb_data(wb_data),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rddata(imem_rddata), .pc(pc),
        .decode_pc(decode_pc), .decode_ir(decode_ir), .decode_valid(decode_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return ~a ^ 16'h0F0F;
    endfunction

    // one-cycle read latency; junk when no read was issued
    always @(posedge clk) imem_rddata <= imem_rd ? mem(imem_addr) : 16'hDEAD;

    typedef struct {
        logic ld; logic [1:0] sel; logic rd, fl, dpl, dil, fwd;
        logic [15:0] xpc, xin, rx, wb;
        logic [15:0] e_pc, e_dpc, e_dir; logic e_dv;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic [1:0] sel, input logic rd, fl, dpl, dil, fwd,
                                input logic [15:0] xpc, xin, rx, wb, e_pc, e_dpc, e_dir, input logic e_dv);
        vec_t v;
        v.ld = ld; v.sel = sel; v.rd = rd; v.fl = fl; v.dpl = dpl; v.dil = dil; v.fwd = fwd;
        v.xpc = xpc; v.xin = xin; v.rx = rx; v.wb = wb;
        v.e_pc = e_pc; v.e_dpc = e_dpc; v.e_dir = e_dir; v.e_dv = e_dv;
        return v;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_ld = v.ld; pc_addr_sel = v.sel; pc_rd = v.rd; flush_f = v.fl; decode_pc_ld = v.dpl;
        decode_ir_ld = v.dil; fwd_pc = v.fwd; x_pc = v.xpc; x_instr = v.xin; rx_data = v.rx; wb_data = v.wb;
    endtask

    task automatic chk_out(input string n, input logic [15:0] p, dp, di, input logic dv);
        chk({n, " pc"}, pc, p);
        chk({n, " imem_addr"}, imem_addr, p);
        chk({n, " decode_pc"}, decode_pc, dp);
        chk({n, " decode_ir"}, decode_ir, di);
        chk({n, " decode_valid"}, 16'(decode_valid), 16'(dv));
    endtask

    vec_t tv[15];
    logic [15:0] m_pc, m_fpc, m_dpc, m_dir, n_pc, n_dir, n_dpc;
    logic        m_fv, m_dv, n_dv;

    initial begin
        tv[0]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0012, 16'h0002, NOP, 0);
        tv[1]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0014, 16'h0012, mem(16'h0010), 1);
        tv[2]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0016, 16'h0014, mem(16'h0012), 1);
        tv[3]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0018, 16'h0016, mem(16'h0014), 1);
        tv[4]  = mk(1, 2, 1, 1, 1, 1, 0, 16'h0020, 16'hFFC0, 0, 0, 16'h001C, 16'h0016, NOP, 0);
        tv[5]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h001E, 16'h001A, NOP, 0);
        tv[6]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0020, 16'h001E, mem(16'h001C), 1);
        tv[7]  = mk(1, 1, 1, 0, 1, 1, 1, 0, 0, 16'h1234, 16'hABCE, 16'hABCE, 16'h0020, mem(16'h001E), 1);
        tv[8]  = mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 16'h1234, 16'hABCE, 16'h1234, 16'h0022, mem(16'h0020), 1);
        for (int i = 9; i < 12; i++)
            tv[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0022, mem(16'h0020), 1);
        tv[12] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 16'hFFFE, 0, 16'hFFFE, 16'h0022, mem(16'h0020), 1);
        tv[13] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0022, mem(16'h0020), 1);
        tv[14] = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0022, mem(16'h0020), 1);

        #1 reset = 1'b1;
        #1 chk_out("reset", RPC, 16'h0000, NOP, 1'b0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive(tv[i]);
            #1 chk($sformatf("vec%0d imem_rd", i), 16'(imem_rd), 16'(tv[i].rd));
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), tv[i].e_pc, tv[i].e_dpc, tv[i].e_dir, tv[i].e_dv);
        end

        drive(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_out("midreset", RPC, 16'h0000, NOP, 1'b0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) chk_out("postreset bubble", 16'h0012, 16'h0002, NOP, 1'b0);
        @(negedge clk) chk_out("postreset first", 16'h0014, 16'h0012, mem(RPC), 1'b1);

        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        m_pc = RPC; m_fv = 0; m_fpc = 0; m_dpc = 0; m_dir = NOP; m_dv = 0;
        for (int c = 0; c < 400; c++) begin
            chk_out($sformatf("rand%0d", c), m_pc, m_dpc, m_dir, m_dv);
            pc_ld = 1'($urandom_range(0, 3) != 0);
            pc_addr_sel = 2'($urandom_range(0, 3));
            pc_rd = 1'($urandom_range(0, 3) != 0);
            flush_f = 1'($urandom_range(0, 7) == 0);
            decode_pc_ld = 1'($urandom_range(0, 4) != 0);
            decode_ir_ld = 1'($urandom_range(0, 4) != 0);
            fwd_pc = 1'($urandom);
            x_pc = 16'($urandom); x_instr = 16'($urandom);
            rx_data = 16'($urandom); wb_data = 16'($urandom);
            #1 chk($sformatf("rand%0d imem_rd", c), 16'(imem_rd), 16'(pc_rd));
            case (pc_addr_sel)
                2'd0: n_pc = 16'(int'(m_pc) + 2);
                2'd1: n_pc = fwd_pc ? wb_data : rx_data;
                2'd2: n_pc = 16'(int'(x_pc) + 2 * int'($signed(x_instr[15:5])));
                default: n_pc = m_pc;
            endcase
            if (!pc_ld) n_pc = m_pc;
            n_dir = m_dir; n_dv = m_dv; n_dpc = m_dpc;
            if (flush_f) begin
                n_dir = NOP; n_dv = 0;
            end else if (decode_ir_ld) begin
                n_dir = m_fv ? mem(m_fpc) : NOP; n_dv = m_fv;
            end
            if (decode_pc_ld && !flush_f) n_dpc = 16'(int'(m_fpc) + 2);
            m_fv = pc_rd && !flush_f; m_fpc = m_pc;
            m_pc = n_pc; m_dir = n_dir; m_dv = n_dv; m_dpc = n_dpc;
            @(negedge clk);
        end
        chk_out("rand final", m_pc, m_dpc, m_dir, m_dv);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
